// File: rtl/wino_pkg.sv
// Shared definitions for the Winograd input path: sequencer state encoding,
// default widths and pipeline constants used by the sequencer and controllers.
package wino_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_PREP   = 3'd2,
        S_STREAM = 3'd3,
        S_NEXT   = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

    // Data controller has two transform register stages to flush after the last loop.
    localparam int DRAIN_CYC       = 2;
    localparam int CH_W_DEFAULT    = 4;
    localparam int OG_W_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/wino_watchdog.sv
// Cycle watchdog: clear reloads zero, enable counts up, expire flags the
// terminal count (TIMEOUT-1) so the owner can abort on that same cycle.
module wino_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = (count_q == LAST);

endmodule

// File: rtl/wino_layer_sequencer.sv
// Layer scheduler: for every (output group, input channel) pair it requests
// weights, then launches one tile loop in the data controller.
// Handshakes: weight_prepare_o is a level request held until the cycle
// weight_ready_i is seen high in LOAD_W; input_prepare_o is a single-cycle
// launch and data_loop_finished_i is only honoured while in STREAM.
module wino_layer_sequencer
    import wino_pkg::*;
#(
    parameter int CH_W    = CH_W_DEFAULT,
    parameter int OG_W    = OG_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [CH_W-1:0] num_in_ch_i,
    input  logic [OG_W-1:0] num_out_grp_i,
    input  logic [7:0]      block_width_i,
    input  logic [7:0]      block_height_i,
    input  logic            size_type_i,
    input  logic            weight_ready_i,
    input  logic            data_loop_finished_i,
    output logic            weight_prepare_o,
    output logic            input_prepare_o,
    output logic [CH_W-1:0] input_id_o,
    output logic [OG_W-1:0] out_grp_o,
    output logic [7:0]      block_width_o,
    output logic [7:0]      block_height_o,
    output logic            size_type_o,
    output logic            acc_clear_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output seq_state_t      state_o
);

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    seq_state_t      state_q, state_d;
    logic [CH_W-1:0] num_in_ch_q, id_q;
    logic [OG_W-1:0] num_out_grp_q, grp_q;
    logic [7:0]      bw_q, bh_q;
    logic            st_q, err_q, acc_clear_q;
    logic [DW-1:0]   drain_cnt_q;
    logic [15:0]     blk_prod;

    logic accept, adv_id, adv_grp, timeout_hit, wd_clear, wd_en, wd_expire;

    assign blk_prod = 16'(block_width_i) * 16'(block_height_i);

    wino_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_en),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control strobes for the datapath.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        adv_id      = 1'b0;
        adv_grp     = 1'b0;
        timeout_hit = 1'b0;
        wd_clear    = 1'b0;
        wd_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = (blk_prod == 16'd0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: if (weight_ready_i) state_d = S_PREP;
            S_PREP: begin
                wd_clear = 1'b1;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                wd_en = 1'b1;
                if (data_loop_finished_i) begin
                    state_d = S_NEXT;
                end else if (wd_expire) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_NEXT: begin
                if (id_q < num_in_ch_q) begin
                    adv_id  = 1'b1;
                    state_d = S_LOAD_W;
                end else if (grp_q < num_out_grp_q) begin
                    adv_grp = 1'b1;
                    state_d = S_LOAD_W;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Layer configuration, loop counters, error flag and clear pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_in_ch_q   <= '0;
            num_out_grp_q <= '0;
            id_q          <= '0;
            grp_q         <= '0;
            bw_q          <= '0;
            bh_q          <= '0;
            st_q          <= 1'b0;
            err_q         <= 1'b0;
            acc_clear_q   <= 1'b0;
        end else begin
            acc_clear_q <= accept | adv_grp;
            if (accept) begin
                num_in_ch_q   <= num_in_ch_i;
                num_out_grp_q <= num_out_grp_i;
                bw_q          <= block_width_i;
                bh_q          <= block_height_i;
                st_q          <= size_type_i;
                id_q          <= '0;
                grp_q         <= '0;
                err_q         <= 1'b0;
            end
            if (adv_id) id_q <= id_q + 1'b1;
            if (adv_grp) begin
                id_q  <= '0;
                grp_q <= grp_q + 1'b1;
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    // Drain counter runs only while in DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  drain_cnt_q <= '0;
        else if (state_q == S_DRAIN) drain_cnt_q <= drain_cnt_q + 1'b1;
        else                        drain_cnt_q <= '0;
    end

    assign weight_prepare_o = (state_q == S_LOAD_W);
    assign input_prepare_o  = (state_q == S_PREP);
    assign done_o           = (state_q == S_DONE);
    assign busy_o           = (state_q != S_IDLE);
    assign input_id_o       = id_q;
    assign out_grp_o        = grp_q;
    assign block_width_o    = bw_q;
    assign block_height_o   = bh_q;
    assign size_type_o      = st_q;
    assign acc_clear_o      = acc_clear_q;
    assign err_o            = err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_wino_layer_sequencer.sv
// Directed and randomized layer runs against a loop-list model of the sequencer.
module tb_wino_layer_sequencer;
    import wino_pkg::*;

    localparam int DRAIN_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [3:0] num_in_ch_i, num_out_grp_i;
    logic [7:0] block_width_i, block_height_i;
    logic       size_type_i, weight_ready_i, data_loop_finished_i;
    logic       weight_prepare_o, input_prepare_o;
    logic [3:0] input_id_o, out_grp_o;
    logic [7:0] block_width_o, block_height_o;
    logic       size_type_o, acc_clear_o, busy_o, done_o, err_o;
    seq_state_t state_o;

    int tests = 0;
    int fails = 0;

    wino_layer_sequencer dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .num_in_ch_i(num_in_ch_i), .num_out_grp_i(num_out_grp_i),
        .block_width_i(block_width_i), .block_height_i(block_height_i),
        .size_type_i(size_type_i), .weight_ready_i(weight_ready_i),
        .data_loop_finished_i(data_loop_finished_i),
        .weight_prepare_o(weight_prepare_o), .input_prepare_o(input_prepare_o),
        .input_id_o(input_id_o), .out_grp_o(out_grp_o),
        .block_width_o(block_width_o), .block_height_o(block_height_o),
        .size_type_o(size_type_o), .acc_clear_o(acc_clear_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .state_o(state_o)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wprep"}, weight_prepare_o, 0);
        chk({tag, "_iprep"}, input_prepare_o, 0);
        chk({tag, "_id_grp"}, {out_grp_o, input_id_o}, 0);
        chk({tag, "_cfg"}, {size_type_o, block_height_o, block_width_o}, 0);
        chk({tag, "_flags"}, {acc_clear_o, busy_o, done_o, err_o}, 0);
    endtask

    task automatic drive_start(input int nch, input int ngrp, input int bw, input int bh, input int st);
        @(negedge clk);
        num_in_ch_i    = 4'(nch);
        num_out_grp_i  = 4'(ngrp);
        block_width_i  = 8'(bw);
        block_height_i = 8'(bh);
        size_type_i    = 1'(st);
        start_i        = 1'b1;
    endtask

    // Runs a whole layer with a weight/data responder and checks every loop launch
    // against the expected (group, channel) order.
    task automatic run_layer(input int nch, input int ngrp, input int bw, input int bh, input int st,
                             input int wlo, input int whi, input int flo, input int fhi,
                             input bit mid_start, input bit stray);
        logic [7:0]  exp_q[$];
        logic [16:0] exp_cfg;
        int cyc = 0, preps = 0, clears = 0, dones = 0;
        int wcnt = 0, wdel = 0, fcnt = 0, last_fin = 0;
        bit streaming = 0, fin_real;
        int total = (nch + 1) * (ngrp + 1);
        for (int g = 0; g <= ngrp; g++)
            for (int c = 0; c <= nch; c++)
                exp_q.push_back(8'((g << 4) | c));
        exp_cfg = {st[0], bh[7:0], bw[7:0]};
        drive_start(nch, ngrp, bw, bh, st);
        while (dones == 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start_i = mid_start && (cyc % 9 == 4);
            if (cyc == 1) begin
                chk("start_err_clear", err_o, 0);
                chk("start_busy", busy_o, 1);
            end
            weight_ready_i = 1'b0;
            if (weight_prepare_o) begin
                if (wcnt == 0) wdel = $urandom_range(whi, wlo);
                if (wcnt >= wdel) begin
                    weight_ready_i = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            fin_real = 1'b0;
            if (streaming) begin
                fcnt--;
                if (fcnt == 0) begin
                    fin_real  = 1'b1;
                    streaming = 0;
                    last_fin  = cyc;
                end
            end
            if (input_prepare_o) begin
                preps++;
                if (exp_q.size() == 0) begin
                    chk("extra_prepare", 1, 0);
                end else begin
                    chk("prep_grp_id", {out_grp_o, input_id_o}, exp_q.pop_front());
                    chk("prep_cfg", {size_type_o, block_height_o, block_width_o}, exp_cfg);
                end
                fcnt = $urandom_range(fhi, flo);
                streaming = 1;
            end
            data_loop_finished_i = fin_real | (stray && weight_prepare_o && ($urandom_range(1, 0) == 1));
            if (acc_clear_o) begin
                chk("acc_clear_grp_id", {out_grp_o, input_id_o}, 8'(clears << 4));
                clears++;
            end
            if (done_o) begin
                dones++;
                chk("done_latency", cyc - last_fin, DRAIN_CYCLES + 2);
            end
        end
        start_i = 1'b0;
        weight_ready_i = 1'b0;
        data_loop_finished_i = 1'b0;
        chk("layer_done_seen", dones, 1);
        chk("prepare_count", preps, total);
        chk("loops_left", exp_q.size(), 0);
        chk("acc_clear_count", clears, ngrp + 1);
        chk("err_after_layer", err_o, 0);
        repeat (2) begin
            @(negedge clk);
            chk("post_done_idle", {busy_o, done_o}, 0);
        end
    endtask

    task automatic wait_for_prepare(input string tag);
        int n = 0;
        while (!input_prepare_o && n < 100) begin
            @(negedge clk);
            start_i = 1'b0;
            weight_ready_i = weight_prepare_o;
            n++;
        end
        weight_ready_i = 1'b0;
        chk(tag, input_prepare_o, 1);
    endtask

    initial begin
        int n, dones;
        reset = 1'b1;
        start_i = 0; num_in_ch_i = 0; num_out_grp_i = 0;
        block_width_i = 0; block_height_i = 0; size_type_i = 0;
        weight_ready_i = 0; data_loop_finished_i = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // 2 channels, 1 group, 2x2, fixed weight and loop latencies.
        run_layer(1, 0, 2, 2, 0, 3, 3, 10, 10, 0, 0);
        // 2 channels x 3 groups.
        run_layer(1, 2, 4, 3, 1, 0, 2, 1, 5, 0, 0);
        // Full-width channel count: 16 channels, 2 groups.
        run_layer(15, 1, 1, 1, 0, 0, 1, 1, 3, 0, 0);

        // Zero-block layers finish without any prepare.
        for (int k = 0; k < 2; k++) begin
            drive_start(2, 1, (k == 0) ? 0 : 9, (k == 0) ? 5 : 0, 0);
            @(negedge clk);
            start_i = 1'b0;
            chk("zero_blk_done", done_o, 1);
            chk("zero_blk_prep", {weight_prepare_o, input_prepare_o}, 0);
            @(negedge clk);
            chk("zero_blk_idle", {busy_o, done_o, weight_prepare_o, input_prepare_o}, 0);
        end

        // Withheld loop completion trips the watchdog.
        drive_start(0, 0, 1, 1, 0);
        wait_for_prepare("timeout_prep_seen");
        n = 0;
        dones = 0;
        while (!err_o && n < 2000) begin
            @(negedge clk);
            n++;
            if (done_o) dones++;
        end
        chk("timeout_cycles", n, TIMEOUT_CYCLES + 1);
        chk("timeout_busy", busy_o, 0);
        chk("timeout_no_done", dones, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err_o, 1);
        // Next accepted start clears the error.
        run_layer(0, 1, 5, 5, 1, 0, 3, 1, 6, 0, 0);

        // Mid-layer start pulses and stray completions in LOAD_W are ignored.
        run_layer(2, 1, 7, 2, 0, 1, 4, 2, 8, 1, 1);

        // Reset in STREAM zeroes outputs immediately.
        drive_start(1, 1, 3, 3, 1);
        wait_for_prepare("reset_prep_seen");
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", busy_o, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        run_layer(1, 1, 3, 3, 1, 0, 2, 1, 4, 0, 0);

        // Randomized layers.
        for (int r = 0; r < 6; r++)
            run_layer($urandom_range(3, 0), $urandom_range(2, 0), $urandom_range(255, 1),
                      $urandom_range(255, 1), $urandom_range(1, 0), 0, 4, 1, 12, r[0], r[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
